tick_scheduler: RTL and testbench

- Programmable 4-channel tick-enable generator running entirely in the clk_25M domain.
- Each channel emits a single-cycle enable strobe plus a 50% square output. Downstream logic uses these as clock enables instead of derived clocks.
- A valid/ready configuration port retunes any channel's divisor at runtime. The new divisor is applied glitch-free at that channel's next wrap.
- Sits between the board clock and the display-scan, keypad, stepper and LED blocks.

---
 rtl/tick_pkg.sv | 18 +
 rtl/tick_chan.sv | 60 ++++++
 rtl/tick_scheduler.sv | 101 ++++++++++
 tb/tb_tick_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared constants and config FSM encoding for tick_scheduler
package tick_pkg;

  localparam int NCH      = 4;
  localparam int DW       = 25;
  localparam int DEF_DIV0 = 25000;
  localparam int DEF_DIV1 = 50000;
  localparam int DEF_DIV2 = 2500;
  localparam int DEF_DIV3 = 25000000;
  localparam int MIN_DIV  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/tick_chan.sv
// rtl/tick_chan.sv - one divider channel: counter, divisor register, tick and square outputs
module tick_chan
  import tick_pkg::*;
#(
  parameter int           W       = DW,
  parameter logic [W-1:0] DEF_DIV = W'(MIN_DIV)
) (
  input  logic         clk_25M,
  input  logic         reset,
  input  logic         run,
  input  logic         sync,
  input  logic         pend,
  input  logic [W-1:0] pdiv,
  output logic         apply,
  output logic         tick,
  output logic         sq
);

  logic [W-1:0] cnt;
  logic [W-1:0] div;
  logic         wrap;

  // div is never below 2, so div-1 cannot underflow
  assign wrap  = (cnt == div - W'(1));

  // a pending divisor lands at the wrap, on sync, or at once while halted
  assign apply = pend & (sync | ~run | wrap);

  // counter, strobe and square state; sync outranks everything including a wrap
  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      div  <= DEF_DIV;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else begin
      if (sync) begin
        cnt  <= '0;
        sq   <= 1'b0;
        tick <= 1'b0;
      end else if (!run) begin
        tick <= 1'b0;
        if (pend) begin
          cnt <= '0;
        end
      end else if (wrap) begin
        cnt  <= '0;
        tick <= 1'b1;
        sq   <= ~sq;
      end else begin
        cnt  <= cnt + W'(1);
        tick <= 1'b0;
      end
      if (apply) begin
        div <= pdiv;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - four-channel tick-enable generator with runtime divisor retune
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int NCH      = tick_pkg::NCH,
  parameter int DW       = tick_pkg::DW,
  parameter int DEF_DIV0 = tick_pkg::DEF_DIV0,
  parameter int DEF_DIV1 = tick_pkg::DEF_DIV1,
  parameter int DEF_DIV2 = tick_pkg::DEF_DIV2,
  parameter int DEF_DIV3 = tick_pkg::DEF_DIV3
) (
  input  logic           clk_25M,
  input  logic           reset,
  input  logic           run,
  input  logic           sync,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [1:0]     cfg_ch,
  input  logic [DW-1:0]  cfg_div,
  output logic           cfg_err,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] sq,
  output logic [NCH-1:0] pend
);

  cfg_state_t    state;
  logic [DW-1:0] pdiv;
  logic [1:0]    pch;
  logic [NCH-1:0] apply;

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_chan
      localparam int DEFD = (i == 0) ? DEF_DIV0 :
                            (i == 1) ? DEF_DIV1 :
                            (i == 2) ? DEF_DIV2 : DEF_DIV3;
      tick_chan #(
        .W       (DW),
        .DEF_DIV (DW'(DEFD))
      ) u_chan (
        .clk_25M (clk_25M),
        .reset   (reset),
        .run     (run),
        .sync    (sync),
        .pend    (pend[i]),
        .pdiv    (pdiv),
        .apply   (apply[i]),
        .tick    (tick[i]),
        .sq      (sq[i])
      );
    end
  endgenerate

  // config FSM: one request outstanding, held in WAIT until the target channel takes it
  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pdiv      <= '0;
      pch       <= '0;
      pend      <= '0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cfg_err <= 1'b0;
          if (cfg_valid) begin
            cfg_ready <= 1'b0;
            if (cfg_div < DW'(MIN_DIV)) begin
              cfg_err <= 1'b1;
              state   <= ERR;
            end else begin
              pdiv         <= cfg_div;
              pch          <= cfg_ch;
              pend[cfg_ch] <= 1'b1;
              state        <= WAIT;
            end
          end
        end
        WAIT: begin
          if (apply[pch]) begin
            pend[pch] <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        ERR: begin
          cfg_err   <= 1'b0;
          cfg_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cfg_err   <= 1'b0;
          cfg_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - directed self-checking bench for tick_scheduler
module tb_tick_scheduler;

  logic        clk_25M = 1'b0;
  logic        reset;
  logic        run;
  logic        sync;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [24:0] cfg_div;
  logic        cfg_err;
  logic [3:0]  tick;
  logic [3:0]  sq;
  logic [3:0]  pend;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       run;
    logic       sync;
    logic [3:0] tick;
    logic [3:0] sq;
  } vec_t;

  vec_t tbl [15];

  always #20 clk_25M = ~clk_25M;

  tick_scheduler #(
    .NCH      (4),
    .DW       (25),
    .DEF_DIV0 (4),
    .DEF_DIV1 (6),
    .DEF_DIV2 (5),
    .DEF_DIV3 (3)
  ) dut (
    .clk_25M   (clk_25M),
    .reset     (reset),
    .run       (run),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .sq        (sq),
    .pend      (pend)
  );

  task automatic step();
    @(posedge clk_25M);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_t;

    tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 4'h0, 4'h0};
    tbl[2]  = '{1'b1, 1'b0, 4'h8, 4'h8};
    tbl[3]  = '{1'b1, 1'b0, 4'h1, 4'h9};
    tbl[4]  = '{1'b1, 1'b0, 4'h4, 4'hD};
    tbl[5]  = '{1'b1, 1'b0, 4'hA, 4'h7};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 4'h7};
    tbl[7]  = '{1'b1, 1'b0, 4'h1, 4'h6};
    tbl[8]  = '{1'b1, 1'b0, 4'h8, 4'hE};
    tbl[9]  = '{1'b1, 1'b0, 4'h4, 4'hA};
    tbl[10] = '{1'b1, 1'b0, 4'h0, 4'hA};
    tbl[11] = '{1'b1, 1'b0, 4'hB, 4'h1};
    tbl[12] = '{1'b0, 1'b0, 4'h0, 4'h1};
    tbl[13] = '{1'b1, 1'b0, 4'h0, 4'h1};
    tbl[14] = '{1'b1, 1'b1, 4'h0, 4'h0};

    reset     = 1'b0;
    run       = 1'b0;
    sync      = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = 25'd0;
    step();
    step();
    step();
    check("rst_tick",  32'(tick),      'h0);
    check("rst_sq",    32'(sq),        'h0);
    check("rst_pend",  32'(pend),      'h0);
    check("rst_err",   32'(cfg_err),   'h0);
    check("rst_ready", 32'(cfg_ready), 'h1);
    reset = 1'b1;

    // free-running defaults, then hold, then sync
    for (int i = 0; i < 15; i++) begin
      run  = tbl[i].run;
      sync = tbl[i].sync;
      step();
      check($sformatf("tbl%0d_tick", i), 32'(tick), 32'(tbl[i].tick));
      check($sformatf("tbl%0d_sq", i),   32'(sq),   32'(tbl[i].sq));
      check($sformatf("tbl%0d_pend", i), 32'(pend), 'h0);
    end
    sync = 1'b0;

    // retune ch1 to 10 while halted: applied on the next cycle
    run       = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_div   = 25'd10;
    step();
    cfg_valid = 1'b0;
    check("halt_req_ready", 32'(cfg_ready), 'h0);
    check("halt_req_pend",  32'(pend),      'h2);
    step();
    check("halt_apply_ready", 32'(cfg_ready), 'h1);
    check("halt_apply_pend",  32'(pend),      'h0);

    // ch1 div 10 -> request 3 at cnt1=5, then a rejected div=1
    run  = 1'b1;
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      cfg_valid = (e == 6) || (e == 17);
      cfg_ch    = 2'd1;
      cfg_div   = (e == 6) ? 25'd3 : 25'd1;
      step();
      cfg_valid = 1'b0;
      check($sformatf("retune_e%0d_tick1", e), 32'(tick[1]),
            (e == 10 || e == 13 || e == 16 || e == 19 || e == 22) ? 'h1 : 'h0);
      check($sformatf("retune_e%0d_err", e), 32'(cfg_err), (e == 17) ? 'h1 : 'h0);
      if (e == 6 || e == 9) begin
        check($sformatf("retune_e%0d_ready", e), 32'(cfg_ready), 'h0);
        check($sformatf("retune_e%0d_pend", e),  32'(pend),      'h2);
      end
      if (e == 10 || e == 18) begin
        check($sformatf("retune_e%0d_ready", e), 32'(cfg_ready), 'h1);
        check($sformatf("retune_e%0d_pend", e),  32'(pend),      'h0);
      end
      if (e == 17) begin
        check("reject_ready", 32'(cfg_ready), 'h0);
        check("reject_pend",  32'(pend),      'h0);
      end
    end

    // divisors now 4,3,5,3: halt 20 cycles with cnt0=2, resume
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int e = 1; e <= 28; e++) begin
      run = !(e >= 7 && e <= 26);
      step();
      if (e == 6) begin
        check("pre_halt_tick", 32'(tick), 'hA);
        check("pre_halt_sq",   32'(sq),   'h5);
      end
      if (e >= 7 && e <= 26) begin
        check($sformatf("halt_e%0d_tick", e), 32'(tick), 'h0);
        check($sformatf("halt_e%0d_sq", e),   32'(sq),   'h5);
      end
      if (e == 27) check("resume_e27_tick", 32'(tick), 'h0);
      if (e == 28) begin
        check("resume_e28_tick", 32'(tick), 'h1);
        check("resume_e28_sq",   32'(sq),   'h4);
      end
    end

    // pending ch2 div 7, then sync on ch0's wrap cycle
    step();
    cfg_valid = 1'b1;
    cfg_ch    = 2'd2;
    cfg_div   = 25'd7;
    step();
    cfg_valid = 1'b0;
    check("sync_pre_pend", 32'(pend), 'h4);
    step();
    check("sync_pre2_pend",  32'(pend),      'h4);
    check("sync_pre2_ready", 32'(cfg_ready), 'h0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_tick",  32'(tick),      'h0);
    check("sync_sq",    32'(sq),        'h0);
    check("sync_pend",  32'(pend),      'h0);
    check("sync_ready", 32'(cfg_ready), 'h1);
    for (int e = 33; e <= 39; e++) begin
      step();
      case (e)
        35, 38:  exp_t = 4'hA;
        36:      exp_t = 4'h1;
        39:      exp_t = 4'h4;
        default: exp_t = 4'h0;
      endcase
      check($sformatf("post_sync_e%0d_tick", e), 32'(tick), 32'(exp_t));
    end

    // reset while ch2 retune is pending
    cfg_valid = 1'b1;
    cfg_ch    = 2'd2;
    cfg_div   = 25'd9;
    step();
    cfg_valid = 1'b0;
    check("wait_pend",  32'(pend),      'h4);
    check("wait_ready", 32'(cfg_ready), 'h0);
    #5;
    reset = 1'b0;
    #1;
    check("mid_rst_tick",  32'(tick),      'h0);
    check("mid_rst_sq",    32'(sq),        'h0);
    check("mid_rst_pend",  32'(pend),      'h0);
    check("mid_rst_ready", 32'(cfg_ready), 'h1);
    check("mid_rst_err",   32'(cfg_err),   'h0);
    step();
    step();
    reset = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      case (e)
        3:       exp_t = 4'h8;
        4:       exp_t = 4'h1;
        5:       exp_t = 4'h4;
        6:       exp_t = 4'hA;
        default: exp_t = 4'h0;
      endcase
      check($sformatf("post_rst_e%0d_tick", e), 32'(tick), 32'(exp_t));
      check($sformatf("post_rst_e%0d_pend", e), 32'(pend), 'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
